// File: rtl/sysid_checker_pkg.sv
// Shared types and default constants for the sysid checker.
// FSM state encoding plus parameter defaults used by the top and its bench.
package sysid_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1520954411;
  localparam int          DEF_TIMEOUT     = 255;
  localparam int          DEF_RECHECK     = 0;

endpackage

// File: rtl/sysid_checker_if.sv
// Control/status plus Avalon-MM read port between the checker (master) and its environment (slave).
// Zero-latency reads; the slave stalls with avm_waitrequest.
interface sysid_checker_if;

  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] captured_id;
  logic [31:0] captured_ts;

  modport master (
    input  start, avm_waitrequest, avm_readdata,
    output avm_address, avm_read, busy, done, id_ok, ts_ok, timeout,
           captured_id, captured_ts
  );

  modport slave (
    output start, avm_waitrequest, avm_readdata,
    input  avm_address, avm_read, busy, done, id_ok, ts_ok, timeout,
           captured_id, captured_ts
  );

endinterface

// File: rtl/sysid_wait_timer.sv
// Counts stalled read cycles; limit_hit flags the stall cycle that would bring the count to LIMIT.
// Zero latency on limit_hit; clear wins over enable.
module sysid_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic limit_hit
);

  localparam int           W    = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  assign limit_hit = enable && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads sysid words 0 (ID) and 1 (timestamp) over Avalon-MM and compares against expected values.
// done 3 cycles after start with no stalls; each stall adds a cycle, bounded by TIMEOUT_CYCLES per read.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int          RECHECK_PERIOD = DEF_RECHECK
) (
  input logic             clk,
  input logic             rst,
  sysid_checker_if.master bus
);

  localparam int RW = (RECHECK_PERIOD > 0) ? $clog2(RECHECK_PERIOD + 1) : 1;

  state_t        state;
  logic          avm_read;
  logic          avm_address;
  logic          busy;
  logic          done;
  logic          id_ok;
  logic          ts_ok;
  logic          timeout;
  logic [31:0]   captured_id;
  logic [31:0]   captured_ts;
  logic [RW-1:0] recheck_cnt;

  logic reading;
  logic complete;
  logic wait_en;
  logic wait_clear;
  logic wait_hit;
  logic recheck_fire;

  assign reading      = (state == RD_ID) || (state == RD_TS);
  assign complete     = reading && !bus.avm_waitrequest;
  assign wait_en      = reading && bus.avm_waitrequest;
  assign wait_clear   = !reading || complete;
  assign recheck_fire = (RECHECK_PERIOD != 0) && (recheck_cnt == RW'(1));

  sysid_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (wait_clear),
    .enable    (wait_en),
    .limit_hit (wait_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
      recheck_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start || recheck_fire) begin
            state       <= RD_ID;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            busy        <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
          end
          // A zero count only occurs straight out of reset: arm the first recheck.
          if (recheck_cnt == '0) begin
            recheck_cnt <= RW'(RECHECK_PERIOD);
          end else begin
            recheck_cnt <= recheck_cnt - 1'b1;
          end
        end
        RD_ID: begin
          if (complete) begin
            captured_id <= bus.avm_readdata;
            state       <= RD_TS;
            avm_address <= 1'b1;
          end else if (wait_hit) begin
            timeout     <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            state       <= DONE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
          end
        end
        RD_TS: begin
          if (complete) begin
            captured_ts <= bus.avm_readdata;
            state       <= DONE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
          end else if (wait_hit) begin
            timeout     <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            state       <= DONE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
          end
        end
        DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
          recheck_cnt <= RW'(RECHECK_PERIOD);
          if (!timeout) begin
            id_ok <= (captured_id == EXPECTED_ID);
            ts_ok <= (captured_ts == EXPECTED_TS);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.avm_read    = avm_read;
  assign bus.avm_address = avm_address;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.id_ok       = id_ok;
  assign bus.ts_ok       = ts_ok;
  assign bus.timeout     = timeout;
  assign bus.captured_id = captured_id;
  assign bus.captured_ts = captured_ts;

endmodule
